// File: rtl/shift_serdes_pkg.sv
// shift_serdes_pkg: shared FSM state encoding and bit-order constants for shift_serdes
package shift_serdes_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;
endpackage

// File: rtl/shift_serdes_bit_counter.sv
// serdes_bit_counter: shift-position counter, 0..MAX
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        return count to zero (wins over inc)
//   inc          advance count by one
//   count        current bit position
//   at_max       count has reached MAX
module serdes_bit_counter #(
    parameter int MAX = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         at_max
);
    localparam int W = $clog2(MAX + 1);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/shift_serdes.sv
// shift_serdes: full-duplex serializer/deserializer with valid/ready load and receive ports
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_val/load_rdy/load_data     transmit word handshake and data
//   lsb_first                       bit order, sampled on the load handshake
//   shift_en                        advance one bit while shifting
//   sin, sout                       serial input and output
//   recv_val/recv_rdy/recv_data     captured word handshake and data
//   busy                            a word is being shifted
module shift_serdes
    import shift_serdes_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_val,
    output logic                load_rdy,
    input  logic [BITWIDTH-1:0] load_data,
    input  logic                lsb_first,
    input  logic                shift_en,
    input  logic                sin,
    output logic                sout,
    output logic                recv_val,
    input  logic                recv_rdy,
    output logic [BITWIDTH-1:0] recv_data,
    output logic                busy
);
    localparam int CNT_W = $clog2(BITWIDTH);

    state_t              state, state_nx;
    logic [BITWIDTH-1:0] regval;
    logic                dir;
    logic [CNT_W-1:0]    cnt;
    logic                at_max;
    logic                load_fire, step;

    assign load_fire = load_val && load_rdy;
    assign step      = (state == SHIFT) && shift_en;

    // Counter restarts on every new word and after the terminal shift.
    serdes_bit_counter #(.MAX(BITWIDTH - 1)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (load_fire || (step && at_max)),
        .inc    (step),
        .count  (cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_rdy = 1'b0;
        recv_val = 1'b0;
        busy     = 1'b0;
        sout     = 1'b0;
        case (state)
            IDLE: begin
                load_rdy = 1'b1;
                if (load_val)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                sout = (dir == DIR_LSB_FIRST) ? regval[0] : regval[BITWIDTH-1];
                if (shift_en && at_max)
                    state_nx = DONE;
            end
            DONE: begin
                recv_val = 1'b1;
                // Accepting the captured word frees the block, so a new word may load in the same cycle.
                load_rdy = recv_rdy;
                if (recv_rdy)
                    state_nx = load_val ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign recv_data = (state == DONE) ? regval : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            regval <= '0;
            dir    <= DIR_MSB_FIRST;
        end else if (load_fire) begin
            regval <= load_data;
            dir    <= lsb_first;
        end else if (step) begin
            regval <= (dir == DIR_LSB_FIRST) ? {sin, regval[BITWIDTH-1:1]}
                                             : {regval[BITWIDTH-2:0], sin};
        end
    end

    cnt_in_range: assert property (@(posedge clk) disable iff (reset) cnt <= CNT_W'(BITWIDTH - 1));
endmodule

// File: tb/tb_shift_serdes.sv
// tb_shift_serdes: randomized self-checking bench for shift_serdes (BITWIDTH = 8)
module tb_shift_serdes;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_val = 1'b0;
    logic          load_rdy;
    logic [BW-1:0] load_data = '0;
    logic          lsb_first = 1'b0;
    logic          shift_en = 1'b0;
    logic          sin = 1'b0;
    logic          sout;
    logic          recv_val;
    logic          recv_rdy = 1'b0;
    logic [BW-1:0] recv_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    shift_serdes #(.BITWIDTH(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_val  (load_val),
        .load_rdy  (load_rdy),
        .load_data (load_data),
        .lsb_first (lsb_first),
        .shift_en  (shift_en),
        .sin       (sin),
        .sout      (sout),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_data (recv_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        #1;
        chk({tag, "_load_rdy"}, 32'(load_rdy), 1);
        chk({tag, "_recv_val"}, 32'(recv_val), 0);
        chk({tag, "_sout"}, 32'(sout), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Present a word and wait (bounded) for the handshake.
    task automatic load_word(input logic [BW-1:0] d, input logic l);
        int n = 0;
        load_val = 1'b1;
        load_data = d;
        lsb_first = l;
        #1;
        while (!load_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("load_rdy", 32'(load_rdy), 1);
        tick();
        load_val = 1'b0;
        load_data = BW'($urandom);
        lsb_first = 1'($urandom);
        chk("busy_after_load", 32'(busy), 1);
    endtask

    // Reference: i-th bit out is d[BW-1-i] (MSB-first) or d[i] (LSB-first);
    // the i-th bit in lands at the mirrored position. Returns the expected capture.
    task automatic shift_word(input logic [BW-1:0] d, input logic l, input logic [BW-1:0] s,
                              input int stall_at, input int stall_len, output logic [BW-1:0] rec);
        logic [BW-1:0] rec_m = '0;
        for (int i = 0; i < BW; i++) begin
            logic exp_out = l ? d[i] : d[BW-1-i];
            logic b = l ? s[i] : s[BW-1-i];
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    shift_en = 1'b0;
                    sin = 1'($urandom);
                    #1;
                    chk("stall_sout", 32'(sout), 32'(exp_out));
                    chk("stall_busy", 32'(busy), 1);
                    tick();
                end
            end
            shift_en = 1'b1;
            sin = b;
            #1;
            chk("sout", 32'(sout), 32'(exp_out));
            chk("recv_val_shift", 32'(recv_val), 0);
            if (l) rec_m[i] = b;
            else   rec_m[BW-1-i] = b;
            tick();
        end
        shift_en = 1'b0;
        #1;
        chk("recv_val", 32'(recv_val), 1);
        chk("recv_data", 32'(recv_data), 32'(rec_m));
        chk("done_sout", 32'(sout), 0);
        chk("done_busy", 32'(busy), 0);
        rec = rec_m;
    endtask

    // Hold off the consumer for bp cycles with a word pending, then accept;
    // optionally load the next word in the same cycle.
    task automatic recv_word(input logic [BW-1:0] rec, input int bp, input bit nxt,
                             input logic [BW-1:0] nd, input logic nl);
        recv_rdy = 1'b0;
        load_val = (bp > 0);
        for (int k = 0; k < bp; k++) begin
            #1;
            chk("bp_recv_val", 32'(recv_val), 1);
            chk("bp_recv_data", 32'(recv_data), 32'(rec));
            chk("bp_load_rdy", 32'(load_rdy), 0);
            tick();
        end
        recv_rdy = 1'b1;
        load_val = nxt;
        load_data = nd;
        lsb_first = nl;
        #1;
        chk("done_load_rdy", 32'(load_rdy), 1);
        tick();
        recv_rdy = 1'b0;
        load_val = 1'b0;
        if (nxt) begin
            chk("b2b_busy", 32'(busy), 1);
            chk("b2b_recv_val", 32'(recv_val), 0);
        end else begin
            check_idle("after_recv");
        end
    endtask

    initial begin
        logic [BW-1:0] rec, d, s, nd;
        logic l, nl;
        bit loaded;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset");
        chk("reset_recv_data", 32'(recv_data), 0);

        load_word(8'h0F, 1'b0);
        shift_word(8'h0F, 1'b0, 8'h3C, BW, 0, rec);
        chk("msb_word", 32'(rec), 32'h3C);
        recv_word(rec, 0, 1'b0, 8'h00, 1'b0);

        load_word(8'h0F, 1'b1);
        shift_word(8'h0F, 1'b1, 8'h3C, BW, 0, rec);
        chk("lsb_word", 32'(rec), 32'h3C);
        recv_word(rec, 0, 1'b0, 8'h00, 1'b0);

        load_word(8'h96, 1'b0);
        shift_word(8'h96, 1'b0, 8'h5A, 4, 3, rec);
        recv_word(rec, 5, 1'b1, 8'hC3, 1'b1);
        shift_word(8'hC3, 1'b1, 8'h81, BW, 0, rec);
        recv_word(rec, 0, 1'b0, 8'h00, 1'b0);

        load_word(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            shift_en = 1'b1;
            sin = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        shift_en = 1'b0;
        check_idle("mid_reset");
        load_word(8'hA5, 1'b0);
        shift_word(8'hA5, 1'b0, 8'h6E, BW, 0, rec);
        recv_word(rec, 0, 1'b0, 8'h00, 1'b0);

        loaded = 1'b0;
        d = '0;
        l = 1'b0;
        for (int w = 0; w < 30; w++) begin
            if (!loaded) begin
                d = BW'($urandom);
                l = 1'($urandom);
                load_word(d, l);
            end
            s = BW'($urandom);
            shift_word(d, l, s, $urandom_range(0, BW + 2), $urandom_range(1, 3), rec);
            nd = BW'($urandom);
            nl = 1'($urandom);
            loaded = 1'($urandom);
            recv_word(rec, $urandom_range(0, 3), loaded, nd, nl);
            d = nd;
            l = nl;
        end
        if (loaded) begin
            shift_word(d, l, BW'($urandom), BW, 0, rec);
            recv_word(rec, 0, 1'b0, 8'h00, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/shift_serdes.md
Name: shift_serdes

Overview:
- Parametrised successor to the team's single-direction shift register.
- A full-duplex serializer/deserializer with three parts:
  - a valid/ready load port for parallel transmit words;
  - a valid/ready receive port for parallel captured words;
  - a selectable bit order per word (MSB-first or LSB-first), chosen at load time.
- Each word shifts out on sout while sin is shifted in; after BITWIDTH enabled shifts the captured word is presented. Sits between SPI-style serial link logic and word-wide datapath blocks.

Parameters:
- BITWIDTH, 32, word width in bits; legal range ≥ 2.
- CNT_W, $clog2(BITWIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- load_val  input  1  transmit word valid
- load_rdy  output  1  block can accept a transmit word
- load_data  input  BITWIDTH  parallel word to serialize
- lsb_first  input  1  bit order for this word; sampled only on load handshake (0 = MSB-first, 1 = LSB-first)
- shift_en  input  1  advance one bit this cycle; ignored outside SHIFT
- sin  input  1  serial input bit, sampled on enabled shift
- sout  output  1  serial output bit currently driven
- recv_val  output  1  captured word valid
- recv_rdy  input  1  consumer accepts captured word
- recv_data  output  BITWIDTH  captured parallel word
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (synchronous, active-high; clock clk). Takes priority over all inputs. Sets:
  - state = IDLE, regval = 0, cnt = 0, dir = 0;
  - outputs after reset: load_rdy = 1, recv_val = 0, sout = 0, busy = 0, recv_data = 0.
- States:
  - IDLE: load_rdy = 1, sout = 0, recv_val = 0.
  - SHIFT: busy = 1, load_rdy = 0, recv_val = 0.
  - DONE: recv_val = 1, recv_data = regval, sout = 0; load_rdy = recv_rdy (combinational).
- Load handshake (load_val && load_rdy):
  - regval <= load_data, dir <= lsb_first, cnt <= 0, state <= SHIFT next cycle.
- SHIFT, shift_en = 1:
  - dir = 0: sout = regval[BITWIDTH-1]; regval <= {regval[BITWIDTH-2:0], sin}.
  - dir = 1: sout = regval[0]; regval <= {sin, regval[BITWIDTH-1:1]}.
  - cnt <= cnt + 1.
  - If cnt == BITWIDTH-1: state <= DONE, cnt <= 0.
  - sout is combinational from regval and dir; it is valid throughout each SHIFT cycle.
- SHIFT, shift_en = 0: regval, cnt and state hold; sout keeps showing the same bit.
- Latency:
  - first bit appears on sout in the cycle after the load handshake;
  - recv_val rises in the cycle after the BITWIDTH-th enabled shift.
- Captured word alignment:
  - MSB-first: first sin bit lands in recv_data[BITWIDTH-1].
  - LSB-first: first sin bit lands in recv_data[0].
- DONE:
  - recv_data is stable while recv_val && !recv_rdy.
  - On recv_rdy without load_val: state <= IDLE.
  - On recv_rdy && load_val: receive and load handshakes complete in the same cycle; state <= SHIFT with the new word (back-to-back, no IDLE bubble).
- load_val in SHIFT, or in DONE with recv_rdy = 0: ignored, no handshake.
- Reset during SHIFT or DONE: the word is dropped; reset values apply next cycle.
- cnt never exceeds BITWIDTH-1; there is no wrap-around beyond the terminal-count transition.

Decomposition:
- Package shift_serdes_pkg:
  - state enum (IDLE, SHIFT, DONE), 2 bits;
  - direction constants DIR_MSB_FIRST = 0, DIR_LSB_FIRST = 1.
- Sub-module serdes_bit_counter, parametrised by MAX = BITWIDTH-1:
  - inputs: clear, inc;
  - outputs: count, at_max;
  - synchronous active-high reset.
- The top level holds the FSM, regval, dir and the output muxing.

Test Plan (BITWIDTH = 8):
- MSB-first: load 0x0F with lsb_first = 0, sin = bits of 0x3C MSB-first, shift_en held high for 8 cycles -> sout = 0,0,0,0,1,1,1,1; recv_val = 1 the next cycle with recv_data = 0x3C.
- LSB-first: load 0x0F with lsb_first = 1, sin = bits of 0x3C LSB-first -> sout = 1,1,1,1,0,0,0,0; recv_data = 0x3C.
- Shift stall: drop shift_en for 3 cycles after bit 4 -> sout holds bit 4, cnt holds, total recv latency grows by 3; recv_data is still correct.
- Backpressure: hold recv_rdy = 0 for 5 cycles in DONE while load_val = 1 -> recv_val and recv_data stay stable, load_rdy = 0, no load occurs; raise recv_rdy -> both handshakes fire and the next cycle is SHIFT with the new word.
- Reset at bit 5 of 8 -> next cycle: state IDLE, load_rdy = 1, recv_val = 0, sout = 0; a following load of 0xA5 serializes correctly from bit 0.
